// File: rtl/adc_serial_pkg.sv
// Shared types and constants for the serial ADC front-end.
// Holds the FSM state enum, frame geometry and the command-bit encoding
// for an MCP3202-class converter (start, single-ended, channel, MSB-first).
package adc_serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_e;

    localparam int unsigned FRAME_BITS = 17;
    localparam int unsigned CMD_BITS   = 4;
    localparam int unsigned DATA_BITS  = 12;
    localparam int unsigned SKIP_BITS  = 5;
    localparam int unsigned BIT_CNT_W  = 5;

    localparam logic CMD_START = 1'b1;
    localparam logic CMD_SGL   = 1'b1;
    localparam logic CMD_MSBF  = 1'b1;

    // Command bit driven on SDO during DCLK period idx; zero after the command.
    function automatic logic cmd_bit(input logic [BIT_CNT_W-1:0] idx, input logic ch);
        logic b;
        b = 1'b0;
        if (idx < BIT_CNT_W'(CMD_BITS)) begin
            case (idx)
                BIT_CNT_W'(0): b = CMD_START;
                BIT_CNT_W'(1): b = CMD_SGL;
                BIT_CNT_W'(2): b = ch;
                default:       b = CMD_MSBF;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/adc_serial_ctrl_if.sv
// Processor-side conversion handshake.
//   start  : conversion request (master -> block)
//   ch     : channel select, latched with start
//   busy   : conversion in progress
//   done   : one-cycle pulse, result valid from this cycle
//   result : last conversion value
interface adc_serial_ctrl_if;
    import adc_serial_pkg::*;

    logic                 start;
    logic                 ch;
    logic                 busy;
    logic                 done;
    logic [DATA_BITS-1:0] result;

    modport master (output start, output ch, input busy, input done, input result);
    modport slave  (input start, input ch, output busy, output done, output result);

endinterface

// File: rtl/adc_sclk_gen.sv
// DCLK generator: half-period counter producing DCLK plus rise/fall strobes.
//   CLK, RST_N : clock, async active-low reset
//   en         : count while high; when low, counter cleared and DCLK low
//   park       : suppress the next low->high toggle (end of frame)
//   dclk       : registered serial clock, idles low
//   rise_c     : last cycle of a low phase (DCLK rises next cycle)
//   fall_c     : last cycle of a high phase (DCLK falls next cycle)
module adc_sclk_gen #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic en,
    input  logic park,
    output logic dclk,
    output logic rise_c,
    output logic fall_c
);
    localparam int unsigned CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] hcnt_q;
    logic             term_c;

    assign term_c = en && (hcnt_q == CNT_W'(CLK_DIV - 1));
    assign rise_c = term_c && !dclk;
    assign fall_c = term_c && dclk;

    // Half-period counter and DCLK toggle
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hcnt_q <= '0;
            dclk   <= 1'b0;
        end else if (!en) begin
            hcnt_q <= '0;
            dclk   <= 1'b0;
        end else if (term_c) begin
            hcnt_q <= '0;
            dclk   <= !dclk && !park;
        end else begin
            hcnt_q <= hcnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/adc_serial_ctrl.sv
// Serial ADC front-end: runs MCP3202-class conversions over DCLK/SCE/SDO/DATA
// and returns the 12-bit result through a start/busy/done handshake.
//   CLK, RST_N : clock, async active-low reset
//   bus        : adc_serial_ctrl_if.slave (start, ch, busy, done, result)
//   DCLK, SCE  : ADC serial clock (idles low) and chip enable (active-low)
//   SDO        : command bits to the ADC
//   DATA       : conversion bits from the ADC (sampled late in DCLK-high, no sync needed)
// Build option ADC_AVG4_EN: each start runs four frames and returns their
// truncated average.
module adc_serial_ctrl
    import adc_serial_pkg::*;
#(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic             CLK,
    input  logic             RST_N,
    adc_serial_ctrl_if.slave bus,
    output logic             DCLK,
    output logic             SCE,
    output logic             SDO,
    input  logic             DATA
);
    localparam int unsigned HOLD_CYC = 2 * CLK_DIV;
    localparam int unsigned HOLD_W   = $clog2(HOLD_CYC);

    state_e               state_q, state_d;
    logic                 rise_c, fall_c, park_c, gen_en_c;
    logic                 hold_last_c, last_frame_c, enter_setup_c, enter_hold_c;
    logic                 res_load_c;
    logic [DATA_BITS-1:0] res_val_c;
    logic [BIT_CNT_W-1:0] bit_cnt_q;
    logic [HOLD_W-1:0]    hold_cnt_q;
    logic [DATA_BITS-1:0] shreg_q, result_q;
    logic                 ch_q, busy_q, done_q, sce_q, sdo_q;

    // DCLK runs only inside a frame; SETUP is simply the first low phase
    assign gen_en_c = (state_q == SETUP) || (state_q == SHIFT);
    // All 17 periods clocked: keep DCLK low through the final low phase
    assign park_c   = (bit_cnt_q == BIT_CNT_W'(FRAME_BITS));

    adc_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .en     (gen_en_c),
        .park   (park_c),
        .dclk   (DCLK),
        .rise_c (rise_c),
        .fall_c (fall_c)
    );

    assign hold_last_c   = (hold_cnt_q == HOLD_W'(HOLD_CYC - 1));
    assign enter_setup_c = (state_d == SETUP) && (state_q != SETUP);
    assign enter_hold_c  = (state_q == SHIFT) && (state_d == HOLD);

`ifdef ADC_AVG4_EN
    localparam int unsigned ACC_BITS = 14;

    logic [1:0]          frame_q;
    logic [ACC_BITS-1:0] acc_q, acc_sum_c;

    assign acc_sum_c    = acc_q + ACC_BITS'(shreg_q);
    assign last_frame_c = (frame_q == 2'd3);
    assign res_load_c   = enter_hold_c && last_frame_c;
    assign res_val_c    = acc_sum_c[ACC_BITS-1:2];

    // Frame counter and 4-sample accumulator
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            frame_q <= '0;
            acc_q   <= '0;
        end else if (state_q == IDLE) begin
            frame_q <= '0;
            acc_q   <= '0;
        end else if (enter_hold_c) begin
            acc_q <= last_frame_c ? '0 : acc_sum_c;
        end else if ((state_q == HOLD) && hold_last_c) begin
            frame_q <= frame_q + 2'd1;
        end
    end
`else
    assign last_frame_c = 1'b1;
    assign res_load_c   = enter_hold_c;
    assign res_val_c    = shreg_q;
`endif

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start)          state_d = SETUP;
            SETUP:   if (rise_c)             state_d = SHIFT;
            SHIFT:   if (rise_c && park_c)   state_d = HOLD;
            HOLD:    if (hold_last_c)        state_d = last_frame_c ? IDLE : SETUP;
            default:                         state_d = IDLE;
        endcase
    end

    // Registered outputs, shift register and frame counters
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bit_cnt_q  <= '0;
            hold_cnt_q <= '0;
            shreg_q    <= '0;
            result_q   <= '0;
            ch_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sce_q      <= 1'b1;
            sdo_q      <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            busy_q     <= (state_d != IDLE);
            sce_q      <= !((state_d == SETUP) || (state_d == SHIFT));
            hold_cnt_q <= ((state_q == HOLD) && !hold_last_c) ? hold_cnt_q + HOLD_W'(1) : '0;

            if ((state_q == IDLE) && bus.start) ch_q <= bus.ch;

            if (enter_setup_c) begin
                bit_cnt_q <= '0;
                sdo_q     <= CMD_START;
            end else if ((state_q == SHIFT) && fall_c) begin
                // End of DCLK-high: sample DATA, advance SDO to the next period's bit
                bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                sdo_q     <= cmd_bit(bit_cnt_q + BIT_CNT_W'(1), ch_q);
                if (bit_cnt_q >= BIT_CNT_W'(SKIP_BITS)) begin
                    shreg_q <= {shreg_q[DATA_BITS-2:0], DATA};
                end
            end

            if (res_load_c) begin
                result_q <= res_val_c;
                done_q   <= 1'b1;
            end
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign SCE        = sce_q;
    assign SDO        = sdo_q;

endmodule
